lif_param_loader_multi: RTL and testbench

// - Serial parameter loader for an array of NUM_NEURONS LIF neurons.
// - Each serial frame is addressed to one neuron slot and carries w_a, w_b, leak and thr_min/thr_max.
// - Fields are staged in a shadow register and committed atomically only after validation.
// - Sits between the chip-level serial config pin and the neuron array; all slots are exported as flat buses.

---
 rtl/lif_param_loader_multi.sv | 180 ++++++++++++++++++
 tb/tb_lif_param_loader_multi.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/lif_param_loader_multi.sv
// Serial parameter loader for NUM_NEURONS LIF slots: shifts in an addressed frame, validates it, commits atomically.
// Optional even-parity trailer bit is enabled by defining LIF_LOADER_PARITY_EN.
module lif_param_loader_multi #(
  parameter int NUM_NEURONS = 4,
  parameter int ADDR_W      = 2,
  parameter int WEIGHT_W    = 3,
  parameter int LEAK_W      = 2,
  parameter int THR_W       = 8,
  parameter logic [WEIGHT_W-1:0] DEFAULT_WA   = 2,
  parameter logic [WEIGHT_W-1:0] DEFAULT_WB   = 2,
  parameter logic [LEAK_W-1:0]   DEFAULT_LEAK = 1,
  parameter logic [THR_W-1:0]    DEFAULT_TMIN = 30,
  parameter logic [THR_W-1:0]    DEFAULT_TMAX = 80
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            serial_data_in,
  input  logic                            load_enable,
  output logic [NUM_NEURONS*WEIGHT_W-1:0] weight_a_flat,
  output logic [NUM_NEURONS*WEIGHT_W-1:0] weight_b_flat,
  output logic [NUM_NEURONS*LEAK_W-1:0]   leak_flat,
  output logic [NUM_NEURONS*THR_W-1:0]    thr_min_flat,
  output logic [NUM_NEURONS*THR_W-1:0]    thr_max_flat,
  output logic [NUM_NEURONS-1:0]          loaded,
  output logic                            busy,
  output logic                            commit_pulse,
  output logic                            frame_err,
  output logic [2:0]                      err_code
);

`ifdef LIF_LOADER_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif

  localparam int OFF_TMAX = PAR_W;
  localparam int OFF_TMIN = OFF_TMAX + THR_W;
  localparam int OFF_LEAK = OFF_TMIN + THR_W;
  localparam int OFF_WB   = OFF_LEAK + LEAK_W;
  localparam int OFF_WA   = OFF_WB + WEIGHT_W;
  localparam int OFF_ADDR = OFF_WA + WEIGHT_W;
  localparam int FRAME_W  = OFF_ADDR + ADDR_W;
  localparam int CNT_W    = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

  localparam logic [2:0] ERR_NONE   = 3'd0;
  localparam logic [2:0] ERR_ABORT  = 3'd1;
  localparam logic [2:0] ERR_ADDR   = 3'd2;
  localparam logic [2:0] ERR_THR    = 3'd3;
  localparam logic [2:0] ERR_PARITY = 3'd4;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, WAIT_LOW} state_t;

  state_t                 state;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   load_enable_prev;
  logic                   commit_q;
  logic [FRAME_W-2:0]     shadow_p0;
  logic [FRAME_W-1:0]     frame_p0;
  logic                   frame_start;
  logic                   last_bit;
  logic                   shift_en;
  logic [2:0]             frame_chk;

  logic [ADDR_W-1:0]      f_addr;
  logic [WEIGHT_W-1:0]    f_wa;
  logic [WEIGHT_W-1:0]    f_wb;
  logic [LEAK_W-1:0]      f_leak;
  logic [THR_W-1:0]       f_tmin;
  logic [THR_W-1:0]       f_tmax;

  // Validation order matters: parity outranks address, address outranks threshold ordering.
  function automatic logic [2:0] check_frame(input logic [FRAME_W-1:0] f);
    logic [ADDR_W-1:0] a;
    logic [THR_W-1:0]  tmin;
    logic [THR_W-1:0]  tmax;
    a    = f[OFF_ADDR +: ADDR_W];
    tmin = f[OFF_TMIN +: THR_W];
    tmax = f[OFF_TMAX +: THR_W];
`ifdef LIF_LOADER_PARITY_EN
    if (^f) return ERR_PARITY;
`endif
    if (32'(a) >= 32'(NUM_NEURONS)) return ERR_ADDR;
    if (tmin > tmax) return ERR_THR;
    return ERR_NONE;
  endfunction

  // The final bit is combined with the shadow so validation and commit happen on the edge that samples it.
  assign frame_p0    = {shadow_p0, serial_data_in};
  assign f_addr      = frame_p0[OFF_ADDR +: ADDR_W];
  assign f_wa        = frame_p0[OFF_WA   +: WEIGHT_W];
  assign f_wb        = frame_p0[OFF_WB   +: WEIGHT_W];
  assign f_leak      = frame_p0[OFF_LEAK +: LEAK_W];
  assign f_tmin      = frame_p0[OFF_TMIN +: THR_W];
  assign f_tmax      = frame_p0[OFF_TMAX +: THR_W];
  assign frame_chk   = check_frame(frame_p0);

  assign frame_start = (state == IDLE) && load_enable && !load_enable_prev;
  assign last_bit    = (bit_cnt == LAST_BIT);
  assign shift_en    = frame_start || ((state == SHIFT) && load_enable && !last_bit);

  assign busy         = (state != IDLE);
  assign commit_pulse = commit_q & enable;

  always_ff @(posedge clk) begin
    if (enable && shift_en) begin
      shadow_p0 <= {shadow_p0[FRAME_W-3:0], serial_data_in};
    end
  end

  // Stage p1: control state, error reporting and slot commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      bit_cnt          <= '0;
      load_enable_prev <= 1'b0;
      commit_q         <= 1'b0;
      frame_err        <= 1'b0;
      err_code         <= ERR_NONE;
      loaded           <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        weight_a_flat[i*WEIGHT_W +: WEIGHT_W] <= DEFAULT_WA;
        weight_b_flat[i*WEIGHT_W +: WEIGHT_W] <= DEFAULT_WB;
        leak_flat[i*LEAK_W +: LEAK_W]         <= DEFAULT_LEAK;
        thr_min_flat[i*THR_W +: THR_W]        <= DEFAULT_TMIN;
        thr_max_flat[i*THR_W +: THR_W]        <= DEFAULT_TMAX;
      end
    end else if (enable) begin
      load_enable_prev <= load_enable;
      commit_q         <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start) begin
            bit_cnt   <= CNT_W'(1);
            frame_err <= 1'b0;
            err_code  <= ERR_NONE;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (!load_enable) begin
            frame_err <= 1'b1;
            err_code  <= ERR_ABORT;
            state     <= IDLE;
          end else if (last_bit) begin
            state <= COMMIT;
            if (frame_chk != ERR_NONE) begin
              frame_err <= 1'b1;
              err_code  <= frame_chk;
            end else begin
              commit_q <= 1'b1;
              for (int i = 0; i < NUM_NEURONS; i++) begin
                if (f_addr == ADDR_W'(i)) begin
                  loaded[i]                             <= 1'b1;
                  weight_a_flat[i*WEIGHT_W +: WEIGHT_W] <= f_wa;
                  weight_b_flat[i*WEIGHT_W +: WEIGHT_W] <= f_wb;
                  leak_flat[i*LEAK_W +: LEAK_W]         <= f_leak;
                  thr_min_flat[i*THR_W +: THR_W]        <= f_tmin;
                  thr_max_flat[i*THR_W +: THR_W]        <= f_tmax;
                end
              end
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        COMMIT: begin
          state <= load_enable ? WAIT_LOW : IDLE;
        end
        WAIT_LOW: begin
          if (!load_enable) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lif_param_loader_multi.sv
// Randomized bench for lif_param_loader_multi: a 4-slot and a 3-slot instance share stimulus and are
// compared against per-instance slot tables updated from decoded frame fields.
module tb_lif_param_loader_multi;

`ifdef LIF_LOADER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FW = 2 + 3 + 3 + 2 + 8 + 8 + PAR;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;
  logic serial_data_in = 1'b0;
  logic load_enable = 1'b0;

  logic [11:0] wa0, wb0;
  logic [7:0]  lk0;
  logic [31:0] tn0, tx0;
  logic [3:0]  ld0;
  logic [8:0]  wa1, wb1;
  logic [5:0]  lk1;
  logic [23:0] tn1, tx1;
  logic [2:0]  ld1;
  logic [1:0]  bz, cp, fe;
  logic [2:0]  ec0, ec1;

  int n_checks = 0;
  int n_fail = 0;
  int nn[2] = '{4, 3};
  int m_wa[2][4], m_wb[2][4], m_lk[2][4], m_tn[2][4], m_tx[2][4];
  logic [3:0] m_ld[2];

  lif_param_loader_multi dut0 (
    .clk(clk), .reset(reset), .enable(enable), .serial_data_in(serial_data_in),
    .load_enable(load_enable), .weight_a_flat(wa0), .weight_b_flat(wb0), .leak_flat(lk0),
    .thr_min_flat(tn0), .thr_max_flat(tx0), .loaded(ld0), .busy(bz[0]),
    .commit_pulse(cp[0]), .frame_err(fe[0]), .err_code(ec0)
  );

  lif_param_loader_multi #(.NUM_NEURONS(3)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .serial_data_in(serial_data_in),
    .load_enable(load_enable), .weight_a_flat(wa1), .weight_b_flat(wb1), .leak_flat(lk1),
    .thr_min_flat(tn1), .thr_max_flat(tx1), .loaded(ld1), .busy(bz[1]),
    .commit_pulse(cp[1]), .frame_err(fe[1]), .err_code(ec1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_defaults();
    for (int k = 0; k < 2; k++) begin
      m_ld[k] = '0;
      for (int i = 0; i < 4; i++) begin
        m_wa[k][i] = 2; m_wb[k][i] = 2; m_lk[k][i] = 1; m_tn[k][i] = 30; m_tx[k][i] = 80;
      end
    end
  endtask

  task automatic check_slots(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_wa0_%0d", tag, i), 32'(wa0[i*3 +: 3]), m_wa[0][i]);
      chk($sformatf("%s_wb0_%0d", tag, i), 32'(wb0[i*3 +: 3]), m_wb[0][i]);
      chk($sformatf("%s_lk0_%0d", tag, i), 32'(lk0[i*2 +: 2]), m_lk[0][i]);
      chk($sformatf("%s_tn0_%0d", tag, i), 32'(tn0[i*8 +: 8]), m_tn[0][i]);
      chk($sformatf("%s_tx0_%0d", tag, i), 32'(tx0[i*8 +: 8]), m_tx[0][i]);
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_wa1_%0d", tag, i), 32'(wa1[i*3 +: 3]), m_wa[1][i]);
      chk($sformatf("%s_wb1_%0d", tag, i), 32'(wb1[i*3 +: 3]), m_wb[1][i]);
      chk($sformatf("%s_lk1_%0d", tag, i), 32'(lk1[i*2 +: 2]), m_lk[1][i]);
      chk($sformatf("%s_tn1_%0d", tag, i), 32'(tn1[i*8 +: 8]), m_tn[1][i]);
      chk($sformatf("%s_tx1_%0d", tag, i), 32'(tx1[i*8 +: 8]), m_tx[1][i]);
    end
    chk({tag, "_loaded0"}, 32'(ld0), 32'(m_ld[0]));
    chk({tag, "_loaded1"}, 32'(ld1), 32'(m_ld[1][2:0]));
  endtask

  task automatic do_reset();
    reset = 1'b1; load_enable = 1'b0; enable = 1'b1;
    step(); step();
    reset = 1'b0;
    model_defaults();
  endtask

  // flip: corrupt one bit (parity builds only); stall_at: bit index before which enable drops for 5 cycles.
  task automatic send_frame(input int a, input int wa, input int wb, input int lk, input int tmin,
                            input int tmax, input bit flip, input int stall_at, input bit mask_chk);
    logic [FW-1:0] fr;
    int exp_err[2];
    logic [25:0] body;
    body = {a[1:0], wa[2:0], wb[2:0], lk[1:0], tmin[7:0], tmax[7:0]};
`ifdef LIF_LOADER_PARITY_EN
    fr = {body, ^body};
    if (flip) begin
      int idx;
      idx = $urandom_range(FW - 1, 0);
      fr[idx] = ~fr[idx];
    end
`else
    fr = body;
`endif
    for (int k = 0; k < 2; k++) begin
      if (PAR == 1 && flip) exp_err[k] = 4;
      else if (a >= nn[k]) exp_err[k] = 2;
      else if (tmin > tmax) exp_err[k] = 3;
      else exp_err[k] = 0;
    end
    for (int b = 0; b < FW; b++) begin
      serial_data_in = fr[FW-1-b];
      load_enable = 1'b1;
      if (b == stall_at && b > 0) begin
        enable = 1'b0;
        repeat (5) step();
        chk("stall_busy", 32'(bz), 32'h3);
        chk("stall_pulse", 32'(cp), 32'h0);
        enable = 1'b1;
      end
      if (b == FW - 1) begin
        chk("pre_last_pulse", 32'(cp), 32'h0);
        check_slots("pre_last");
      end
      step();
    end
    for (int k = 0; k < 2; k++) begin
      if (exp_err[k] == 0) begin
        m_wa[k][a] = wa; m_wb[k][a] = wb; m_lk[k][a] = lk; m_tn[k][a] = tmin; m_tx[k][a] = tmax;
        m_ld[k][a] = 1'b1;
      end
      chk($sformatf("pulse%0d", k), 32'(cp[k]), 32'(exp_err[k] == 0));
      chk($sformatf("ferr%0d", k), 32'(fe[k]), 32'(exp_err[k] != 0));
    end
    chk("ecode0", 32'(ec0), exp_err[0]);
    chk("ecode1", 32'(ec1), exp_err[1]);
    check_slots("commit");
    if (mask_chk) begin
      enable = 1'b0;
      #1;
      chk("pulse_masked", 32'(cp), 32'h0);
      enable = 1'b1;
    end
    serial_data_in = $urandom_range(1, 0);
    step();
    chk("pulse_one_cycle", 32'(cp), 32'h0);
    chk("waitlow_busy", 32'(bz), 32'h3);
    load_enable = 1'b0;
    step();
    chk("idle_busy", 32'(bz), 32'h0);
    check_slots("after");
  endtask

  task automatic send_abort(input int nbits);
    for (int b = 0; b < nbits; b++) begin
      serial_data_in = $urandom_range(1, 0);
      load_enable = 1'b1;
      step();
    end
    chk("abort_busy_mid", 32'(bz), 32'h3);
    load_enable = 1'b0;
    step();
    chk("abort_ferr", 32'(fe), 32'h3);
    chk("abort_code0", 32'(ec0), 32'd1);
    chk("abort_code1", 32'(ec1), 32'd1);
    chk("abort_busy", 32'(bz), 32'h0);
    chk("abort_pulse", 32'(cp), 32'h0);
    check_slots("abort");
  endtask

  initial begin
    model_defaults();
    do_reset();
    chk("rst_busy", 32'(bz), 32'h0);
    chk("rst_pulse", 32'(cp), 32'h0);
    chk("rst_ferr", 32'(fe), 32'h0);
    chk("rst_code", 32'({ec1, ec0}), 32'h0);
    check_slots("rst");

    send_frame(2, 5, 1, 3, 20, 100, 1'b0, -1, 1'b1);
    send_frame(1, 7, 6, 2, 90, 40, 1'b0, -1, 1'b0);
    send_abort(10);
    send_frame(0, 3, 4, 0, 10, 10, 1'b0, -1, 1'b0);
    send_frame(3, 1, 2, 1, 5, 200, 1'b0, -1, 1'b0);
    send_frame(1, 6, 3, 2, 0, 255, 1'b0, 12, 1'b0);
`ifdef LIF_LOADER_PARITY_EN
    send_frame(0, 2, 5, 3, 40, 60, 1'b1, -1, 1'b0);
    send_frame(0, 2, 5, 3, 40, 60, 1'b0, -1, 1'b0);
`endif

    // Reset in the middle of a frame discards it and reverts every slot.
    for (int b = 0; b < 8; b++) begin
      serial_data_in = $urandom_range(1, 0);
      load_enable = 1'b1;
      step();
    end
    do_reset();
    chk("midrst_busy", 32'(bz), 32'h0);
    check_slots("midrst");

    for (int n = 0; n < 40; n++) begin
      int stall;
      bit flip;
      stall = ($urandom_range(3, 0) == 0) ? int'($urandom_range(FW - 2, 1)) : -1;
      flip = (PAR == 1) && ($urandom_range(2, 0) == 0);
      if ($urandom_range(7, 0) == 0) send_abort($urandom_range(FW - 2, 1));
      send_frame($urandom_range(3, 0), $urandom_range(7, 0), $urandom_range(7, 0),
                 $urandom_range(3, 0), $urandom_range(255, 0), $urandom_range(255, 0),
                 flip, stall, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
